mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the core's instruction-fetch path and its load/store path.
- Requests use a valid/ready handshake; responses are fire-and-forget.
- One transaction is outstanding at a time, with a fixed memory read latency.
- Data requests have priority, and a starvation counter guarantees fetch progress. Sits between the fetch/LSU logic and the memory instance inside the top level.

Parameters:
- AW, 32, address width
- DW, 32, data width; must be a multiple of 8
- MEM_LAT, 1, memory cycles from the mem_en cycle to valid mem_rdata; must be ≥1
- MAX_STARVE, 3, consecutive data grants allowed while fetch waits before fetch is forced

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  AW  fetch address
- if_rsp_valid  out  1  fetch read data valid, one-cycle pulse
- if_rsp_rdata  out  DW  fetch read data
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted this cycle
- d_addr  in  AW  data address
- d_we  in  1  1 = write, 0 = read
- d_be  in  DW/8  write byte enables
- d_wdata  in  DW  write data
- d_rsp_valid  out  1  data response pulse (read data or write ack)
- d_rsp_rdata  out  DW  data read data; 0 for write acks
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_be  out  DW/8  memory byte enables
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; all outputs are 0; the latched request, owner and starve_cnt are cleared.
  - An in-flight transaction is dropped: no response pulse follows reset release.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Acceptance:
  - Requests are accepted only in IDLE or RESP.
  - ready is combinational and asserted to at most one requester, the granted one.
  - On accept, the block latches addr, we, be, wdata and owner, then goes to ISSUE.
  - Requesters hold valid and payload stable until ready.
- ISSUE (1 cycle):
  - mem_en=1 and mem_addr = latched addr.
  - mem_we / mem_be / mem_wdata are driven from the latched request for data writes; mem_we=0 and mem_be=all-ones for reads.
  - Then goes to WAIT.
- WAIT (MEM_LAT cycles, down-counter):
  - mem_en=0.
  - In the last WAIT cycle, mem_rdata is registered into the owner's rsp_rdata (writes register 0). Then goes to RESP.
- RESP (1 cycle):
  - The owner's rsp_valid=1; the other requester's rsp_valid=0.
  - Next state is ISSUE if a new request is accepted this cycle, else IDLE.
  - rsp_rdata holds its value until the next response for that owner.
- Timing with accept in cycle T:
  - mem_en in T+1
  - rsp_valid in T+2+MEM_LAT
  - back-to-back throughput: one transaction per MEM_LAT+2 cycles
- Arbitration (when both valid at an accept point):
  - The data request wins unless starve_cnt == MAX_STARVE, in which case fetch wins.
  - If only one requester is valid, it wins.
- starve_cnt:
  - +1 (saturating at MAX_STARVE) when data is granted while if_req_valid=1.
  - Cleared when fetch is granted, or when data is granted with if_req_valid=0.
- No request ever receives ready outside IDLE/RESP; requests are never dropped or duplicated.
- Address and byte enables pass through unmodified; the arbiter performs no alignment check.

Decomposition:
- Shared package risc5_mem_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP)
  - the owner enum (OWN_IF, OWN_D)
  - the default widths
- One sub-module is natural: mem_arb_grant. It takes both valids and starve_cnt, and produces the one-hot grant plus the next starve_cnt.
- The FSM, latency counter and response routing stay in mem_port_arbiter.

Test Plan:
- Fetch read alone (DW=32, MEM_LAT=1): if_req_valid with if_addr=0x100 at T, memory returns 0xDEADBEEF.
  - Required: if_req_ready=1 at T; mem_en=1 with mem_addr=0x100 at T+1; if_rsp_valid=1 with rdata 0xDEADBEEF at T+3; d_rsp_valid stays 0.
- Data write: d_we=1, d_addr=0x200, d_be=4'b0011, d_wdata=0x12345678.
  - Required: mem_en=1, mem_we=1, mem_be=0011, mem_wdata=0x12345678 in the ISSUE cycle.
  - Required: d_rsp_valid pulse with d_rsp_rdata=0 at T+3.
- Contention: both requesters valid continuously, MAX_STARVE=3.
  - Required grant order: D, D, D, IF, D, D, D, IF.
  - Required: one accept every 3 cycles.
- Back-to-back: data held valid for 3 transactions.
  - Required: accepts at T, T+3, T+6; mem_en in T+1, T+4, T+7; no idle bubble between them.
- Reset mid-operation: rst=0 during WAIT of a fetch read.
  - Required: all outputs 0 immediately.
  - Required: after rst=1, no if_rsp_valid appears and starve_cnt=0; the next request completes normally.
- MEM_LAT=3: a single data read.
  - Required: rsp_valid at T+5, with data sampled in T+4.

Source files
------------

// File: rtl/risc5_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Contents:
//   - default parameter values (address/data width, memory latency, starvation limit)
//   - arbiter FSM state enum and transaction owner enum
//   - grant vector bit positions
//   - cnt_width(): width of a counter that must hold 0..max_val
package risc5_mem_pkg;

  localparam int DEF_AW         = 32;
  localparam int DEF_DW         = 32;
  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_MAX_STARVE = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Bit positions inside the one-hot grant vector
  localparam int GNT_IF = 0;
  localparam int GNT_D  = 1;

  // A counter that must hold values 0..max_val needs at least one bit
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake and memory-side signal around the arbiter.
// Parameters: AW address width, DW data width (multiple of 8).
// Modports:
//   slave  - the arbiter's view: request inputs and mem_rdata in;
//            ready, responses and the memory strobe/address/data out
//   master - the environment's view (fetch unit, LSU and memory together)
interface mem_port_arbiter_if
  import risc5_mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic              if_req_valid;
  logic              if_req_ready;
  logic [AW-1:0]     if_addr;
  logic              if_rsp_valid;
  logic [DW-1:0]     if_rsp_rdata;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [AW-1:0]     d_addr;
  logic              d_we;
  logic [DW/8-1:0]   d_be;
  logic [DW-1:0]     d_wdata;
  logic              d_rsp_valid;
  logic [DW-1:0]     d_rsp_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW/8-1:0]   mem_be;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  modport slave (
    input  if_req_valid, if_addr,
    input  d_req_valid, d_addr, d_we, d_be, d_wdata,
    input  mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_rdata,
    output d_req_ready, d_rsp_valid, d_rsp_rdata,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output if_req_valid, if_addr,
    output d_req_valid, d_addr, d_we, d_be, d_wdata,
    output mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_rdata,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Grant decision between fetch and data requesters, purely combinational.
// Data normally wins; once fetch has been passed over MAX_STARVE times in a
// row, fetch is forced through.
// Ports:
//   if_valid    in   fetch request valid
//   d_valid     in   data request valid
//   starve_cnt  in   consecutive data grants while fetch waited
//   grant       out  one-hot grant, bit GNT_IF / GNT_D
//   starve_nxt  out  starvation count to store if this grant is taken
module mem_arb_grant
  import risc5_mem_pkg::*;
#(
  parameter int MAX_STARVE = DEF_MAX_STARVE,
  parameter int SCW        = cnt_width(MAX_STARVE)
) (
  input  logic           if_valid,
  input  logic           d_valid,
  input  logic [SCW-1:0] starve_cnt,
  output logic [1:0]     grant,
  output logic [SCW-1:0] starve_nxt
);

  localparam logic [SCW-1:0] STARVE_MAX = SCW'(MAX_STARVE);

  logic fetch_forced;

  // Pick the winner and compute the counter value that goes with it.
  // The counter only advances while fetch is actually waiting; an
  // uncontested data grant or any fetch grant resets it.
  always_comb begin
    grant        = '0;
    starve_nxt   = starve_cnt;
    fetch_forced = if_valid && (starve_cnt == STARVE_MAX);
    if (d_valid && !fetch_forced) begin
      grant[GNT_D] = 1'b1;
      if (!if_valid) begin
        starve_nxt = '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_nxt = starve_cnt + SCW'(1);
      end
    end else if (if_valid) begin
      grant[GNT_IF] = 1'b1;
      starve_nxt    = '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One transaction is outstanding at a time: accept -> ISSUE (mem_en) ->
// MEM_LAT cycles of WAIT -> RESP (one-cycle response pulse to the owner).
// A new request may be accepted in IDLE or in the RESP cycle, giving one
// transaction every MEM_LAT+2 cycles when requests are back to back.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous reset, active low
//   bus  slave modport of mem_port_arbiter_if (fetch, data and memory sides)
module mem_port_arbiter
  import risc5_mem_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int MAX_STARVE = DEF_MAX_STARVE
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int BW  = DW / 8;
  localparam int LCW = cnt_width(MEM_LAT - 1);
  localparam int SCW = cnt_width(MAX_STARVE);

  arb_state_e      state_q;
  arb_state_e      state_d;
  owner_e          owner_q;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [BW-1:0]   be_q;
  logic [DW-1:0]   wdata_q;
  logic [LCW-1:0]  lat_q;
  logic [SCW-1:0]  starve_q;
  logic [SCW-1:0]  starve_nxt;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   d_rdata_q;
  logic [1:0]      grant;
  logic            accept_window;
  logic            if_accept;
  logic            d_accept;
  logic            accept;
  logic            d_write;
  logic            last_wait;

  mem_arb_grant #(
    .MAX_STARVE (MAX_STARVE),
    .SCW        (SCW)
  ) u_grant (
    .if_valid   (bus.if_req_valid),
    .d_valid    (bus.d_req_valid),
    .starve_cnt (starve_q),
    .grant      (grant),
    .starve_nxt (starve_nxt)
  );

  // ready is only offered while the port is free; gating with rst keeps
  // every output low for the whole time reset is held
  assign accept_window = rst && ((state_q == IDLE) || (state_q == RESP));
  assign if_accept     = accept_window && grant[GNT_IF];
  assign d_accept      = accept_window && grant[GNT_D];
  assign accept        = if_accept || d_accept;
  assign d_write       = d_accept && bus.d_we;
  assign last_wait     = (state_q == WAIT) && (lat_q == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (lat_q == '0) state_d = RESP;
      RESP:    state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, latency counter, starvation counter and read-data
  // capture. Reads drive all-ones byte enables and zero write data so the
  // memory sees a clean read strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      lat_q      <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (accept) begin
        owner_q  <= d_accept ? OWN_D : OWN_IF;
        addr_q   <= d_accept ? bus.d_addr : bus.if_addr;
        we_q     <= d_write;
        be_q     <= d_write ? bus.d_be : {BW{1'b1}};
        wdata_q  <= d_write ? bus.d_wdata : '0;
        starve_q <= starve_nxt;
      end
      if (state_q == ISSUE) begin
        lat_q <= LCW'(MEM_LAT - 1);
      end else if ((state_q == WAIT) && (lat_q != '0)) begin
        lat_q <= lat_q - LCW'(1);
      end
      if (last_wait) begin
        if (owner_q == OWN_IF) begin
          if_rdata_q <= we_q ? '0 : bus.mem_rdata;
        end else begin
          d_rdata_q  <= we_q ? '0 : bus.mem_rdata;
        end
      end
    end
  end

  // Output decode: memory strobe only in ISSUE, response pulse only in RESP
  always_comb begin
    bus.if_req_ready = if_accept;
    bus.d_req_ready  = d_accept;
    bus.mem_en       = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_be       = '0;
    bus.mem_wdata    = '0;
    bus.if_rsp_valid = 1'b0;
    bus.d_rsp_valid  = 1'b0;
    if (state_q == ISSUE) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = we_q;
      bus.mem_addr  = addr_q;
      bus.mem_be    = be_q;
      bus.mem_wdata = wdata_q;
    end
    if (state_q == RESP) begin
      bus.if_rsp_valid = (owner_q == OWN_IF);
      bus.d_rsp_valid  = (owner_q == OWN_D);
    end
  end

  assign bus.if_rsp_rdata = if_rdata_q;
  assign bus.d_rsp_rdata  = d_rdata_q;

endmodule
